// File: rtl/ext_int_source.sv
// External interrupt generator: PC-match and periodic request sources feed a
// saturating pending counter that drives a level interrupt with an ack/gap handshake.
module ext_int_source #(
  parameter logic [31:0] INT_ADDR   = 32'h0000_7F20,
  parameter int          GAP_CYCLES = 4,
  parameter int          PEND_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       macroscopic_pc,
  input  logic [31:0]       m_int_addr,
  input  logic [3:0]        m_int_byteen,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_wdata,
  output logic              interrupt,
  output logic [PEND_W-1:0] pending,
  output logic              ovf,
  output logic              spurious
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PEND_W+1:0] PEND_MAX = {2'b00, {PEND_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GAP
  } state_t;

  state_t             state, state_next;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;
  logic [31:0]        trig_pc;
  logic [31:0]        period;
  logic [1:0]         ctrl;
  logic [31:0]        countdown;
  logic               prev_pc_match;

  logic               pc_match;
  logic               pc_req;
  logic               per_active;
  logic               per_req;
  logic               ack;
  logic               ack_taken;
  logic [PEND_W+1:0]  pend_sum;
  logic [PEND_W+1:0]  pend_net;
  logic [PEND_W-1:0]  pending_next;
  logic               lost;

  assign pc_match   = (macroscopic_pc == trig_pc);
  assign pc_req     = ctrl[0] & pc_match & ~prev_pc_match;
  assign per_active = ctrl[1] & (period != 32'd0);
  assign per_req    = per_active & (countdown == 32'd1);
  assign ack        = (m_int_addr == INT_ADDR) && (m_int_byteen == 4'b0001);
  assign ack_taken  = ack & (state == ASSERT);

  // Up to two requests and one ack per cycle; the sum is kept two bits wider so the clamp can see the overflow.
  always_comb begin
    pend_sum     = {2'b00, pending} + {{(PEND_W+1){1'b0}}, pc_req}
                                    + {{(PEND_W+1){1'b0}}, per_req};
    pend_net     = pend_sum;
    pending_next = pending;
    lost         = 1'b0;
    if (ack_taken && (pend_sum != '0))
      pend_net = pend_sum - {{(PEND_W+1){1'b0}}, 1'b1};
    if (pend_net > PEND_MAX) begin
      pending_next = '1;
      lost         = 1'b1;
    end else begin
      pending_next = pend_net[PEND_W-1:0];
    end
  end

  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    case (state)
      IDLE:   if (pending != '0) state_next = ASSERT;
      ASSERT: if (ack) begin
                state_next   = GAP;
                gap_cnt_next = GAP_W'(GAP_CYCLES - 1);
              end
      GAP:    if (gap_cnt == '0) state_next = IDLE;
              else gap_cnt_next = gap_cnt - GAP_W'(1);
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      interrupt <= 1'b0;
    end else begin
      state     <= state_next;
      gap_cnt   <= gap_cnt_next;
      interrupt <= (state_next == ASSERT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending       <= '0;
      ovf           <= 1'b0;
      spurious      <= 1'b0;
      prev_pc_match <= 1'b0;
    end else begin
      pending       <= pending_next;
      ovf           <= ovf | lost;
      spurious      <= spurious | (ack & (state != ASSERT));
      prev_pc_match <= pc_match;
    end
  end

  // A PERIOD write restarts the countdown; otherwise the reload lands on the same edge the request fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_pc   <= '0;
      period    <= '0;
      ctrl      <= '0;
      countdown <= '0;
    end else begin
      if (cfg_we && (cfg_sel == 2'd0)) trig_pc <= cfg_wdata;
      if (cfg_we && (cfg_sel == 2'd1)) period  <= cfg_wdata;
      if (cfg_we && (cfg_sel == 2'd2)) ctrl    <= cfg_wdata[1:0];
      if (cfg_we && (cfg_sel == 2'd1))
        countdown <= cfg_wdata;
      else if (per_active)
        countdown <= (countdown <= 32'd1) ? period : countdown - 32'd1;
    end
  end

endmodule

// File: tb/tb_ext_int_source.sv
// Randomized and directed bench for ext_int_source; a per-cycle reference model
// fills a scoreboard that a negedge monitor drains against the DUT outputs.
module tb_ext_int_source;

  localparam logic [31:0] INT_ADDR = 32'h0000_7F20;
  localparam int GAP  = 4;
  localparam int PMAX = 15;

  typedef struct packed {
    logic       intr;
    logic [3:0] pend;
    logic       ovf;
    logic       spur;
  } obs_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        interrupt;
  logic [3:0]  pending;
  logic        ovf;
  logic        spurious;

  ext_int_source #(.INT_ADDR(INT_ADDR), .GAP_CYCLES(GAP), .PEND_W(4)) dut (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr),
    .m_int_byteen(byteen), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .interrupt(interrupt), .pending(pending), .ovf(ovf), .spurious(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cycle  = 0;
  obs_t sb[$];
  obs_t mon_exp, mon_act;

  logic [31:0] m_trig, m_period, m_cd;
  logic [1:0]  m_ctrl;
  int          m_pend, m_edge, m_eligible;
  bit          m_last, m_intr, m_ovf, m_spur;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_trig = '0; m_period = '0; m_cd = '0; m_ctrl = '0;
    m_pend = 0; m_edge = 0; m_eligible = 0;
    m_last = 0; m_intr = 0; m_ovf = 0; m_spur = 0;
  endtask

  // Interrupt may re-rise no earlier than GAP+1 edges after the acknowledging edge.
  task automatic model_step();
    bit is_ack, match;
    int req, np, old_pend;
    obs_t e;
    m_edge++;
    n_cycle++;
    is_ack = (addr == INT_ADDR) && (byteen == 4'b0001);
    req = 0;
    match = (pc == m_trig);
    if (m_ctrl[0] && match && !m_last) req++;
    m_last = match;
    if (m_ctrl[1] && m_period != 0) begin
      if (m_cd == 1) begin req++; m_cd = m_period; end
      else m_cd = m_cd - 1;
    end
    old_pend = m_pend;
    np = m_pend + req - ((is_ack && m_intr) ? 1 : 0);
    if (np > PMAX) begin m_ovf = 1; np = PMAX; end
    if (np < 0) np = 0;
    if (is_ack && !m_intr) m_spur = 1;
    if (m_intr) begin
      if (is_ack) begin m_intr = 0; m_eligible = m_edge + GAP + 1; end
    end else if (m_edge >= m_eligible && old_pend != 0) begin
      m_intr = 1;
    end
    m_pend = np;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: m_trig = cfg_wdata;
        2'd1: begin m_period = cfg_wdata; m_cd = cfg_wdata; end
        2'd2: m_ctrl = cfg_wdata[1:0];
        default: ;
      endcase
    end
    e.intr = m_intr; e.pend = 4'(m_pend); e.ovf = m_ovf; e.spur = m_spur;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] a, input logic [3:0] be,
                               input logic we, input logic [1:0] sel, input logic [31:0] wd);
    pc = p; addr = a; byteen = be; cfg_we = we; cfg_sel = sel; cfg_wdata = wd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input logic [31:0] p);
    for (int i = 0; i < n; i++) applyStimulus(p, 32'h0, 4'h0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic ackOnce(input logic [31:0] p);
    applyStimulus(p, INT_ADDR, 4'b0001, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [31:0] wd);
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b1, sel, wd);
  endtask

  task automatic asyncReset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_intr_drop", int'(interrupt), 0);
    checkOutput("async_pend_clear", int'(pending), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      mon_act = {interrupt, pending, ovf, spurious};
      checkOutput($sformatf("outputs_cycle%0d", n_cycle), int'(mon_act), int'(mon_exp));
    end
  end

  initial begin
    logic [31:0] p, a, wd;
    logic [3:0]  be;
    logic        we;
    logic [1:0]  sel;
    int          budget;

    reset = 1'b0; pc = '0; addr = '0; byteen = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", int'({interrupt, pending, ovf, spurious}), 0);
    reset = 1'b1;

    // Stalled PC on the trigger address yields a single request.
    cfgWrite(2'd0, 32'h3010);
    cfgWrite(2'd2, 32'h1);
    idle(5, 32'h3010);
    checkOutput("stall_single_req", int'(pending), 1);
    checkOutput("stall_intr_high", int'(interrupt), 1);
    idle(2, 32'h0);

    ackOnce(32'h0);
    checkOutput("ack_drops_intr", int'(interrupt), 0);
    idle(6, 32'h0);
    checkOutput("ack_low_gap", int'({interrupt, pending, spurious}), 0);

    // Periodic saturation with no acks.
    cfgWrite(2'd2, 32'h2);
    cfgWrite(2'd1, 32'd10);
    idle(175, 32'h0);
    checkOutput("sat_pending", int'(pending), PMAX);
    checkOutput("sat_ovf", int'(ovf), 1);

    cfgWrite(2'd2, 32'h0);
    budget = 300;
    while (!(m_intr && m_pend == 5) && budget > 0) begin
      if (m_intr) ackOnce(32'h0); else idle(1, 32'h0);
      budget--;
    end
    if (budget == 0) checkOutput("drain_to_5_timeout", 0, 1);
    checkOutput("pre_reset_intr", int'(interrupt), 1);
    asyncReset();
    idle(2, 32'h0);

    ackOnce(32'h0);
    idle(3, 32'h0);
    checkOutput("spurious_sticky", int'({interrupt, pending, spurious}), 1);

    // PC and periodic requests collide with an ack while pending is 3.
    cfgWrite(2'd0, 32'h5000);
    cfgWrite(2'd1, 32'd4);
    cfgWrite(2'd2, 32'h3);
    budget = 100;
    while (!(m_pend == 3 && m_cd == 1 && m_intr) && budget > 0) begin
      idle(1, 32'h0);
      budget--;
    end
    if (budget == 0) checkOutput("collide_setup_timeout", 0, 1);
    ackOnce(32'h5000);
    checkOutput("collide_pending", int'(pending), 4);
    idle(10, 32'h0);

    p = 32'h5000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 2))
          0: p = 32'h5000;
          1: p = 32'h5004;
          default: p = 32'h6000;
        endcase
      end
      if ($urandom_range(0, 3) == 0) begin
        a  = ($urandom_range(0, 7) == 0) ? (INT_ADDR ^ 32'h4) : INT_ADDR;
        be = ($urandom_range(0, 5) == 0) ? 4'b0011 : 4'b0001;
      end else begin
        a = 32'h0; be = 4'h0;
      end
      we  = ($urandom_range(0, 11) == 0);
      sel = 2'($urandom_range(0, 3));
      case (sel)
        2'd0: wd = ($urandom_range(0, 1) == 0) ? 32'h5000 : 32'h5004;
        2'd1: wd = 32'($urandom_range(0, 12));
        default: wd = $urandom;
      endcase
      applyStimulus(p, a, be, we, sel, wd);
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
